fifo_shadow_checker: RTL and testbench

FIFO_SHADOW_CHECKER -- requirements
Module: fifo_shadow_checker

---
 rtl/fifo_shadow_checker.sv | 163 ++++++++++++++++
 tb/tb_fifo_shadow_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_shadow_checker.sv
// fifo_shadow_checker: shadow model of a FIFO that flags flag, status and data mismatches.
// Macro FIFO_CHK_STICKY_EN makes error_flags sticky until reset.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en, rd_en, data_in     observed FIFO requests and write data
//   data_out                  observed registered read data
//   full, empty, almostfull, almostempty  observed combinational flags
//   wr_ack, overflow, underflow           observed registered status
//   freeze                    hold results, keep tracking the FIFO
//   correct_count, error_count  saturating tallies of evaluated cycles
//   mismatch                  last evaluated cycle had any mismatch
//   error_flags               per-signal mismatch bits
//     [0]full [1]empty [2]almostfull [3]almostempty
//     [4]wr_ack [5]overflow [6]underflow [7]data_out
module fifo_shadow_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  freeze,
  output logic [CNT_W-1:0]      correct_count,
  output logic [CNT_W-1:0]      error_count,
  output logic                  mismatch,
  output logic [7:0]            error_flags
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0]    PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_AF   = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                  wack_q, wack_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  armed_q, armed_d;
  logic [FIFO_WIDTH-1:0] edata_q, edata_d;

  logic [CNT_W-1:0] cc_q, cc_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic             mm_q, mm_d;
  logic [7:0]       ef_q, ef_d;

  logic       wr_acc;
  logic       rd_acc;
  logic [7:0] err_v;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign wr_acc = wr_en && (cnt_q != CNT_FULL);
  assign rd_acc = rd_en && (cnt_q != '0);

  always_comb begin
    wptr_d  = wr_acc ? ptr_nxt(wptr_q) : wptr_q;
    rptr_d  = rd_acc ? ptr_nxt(rptr_q) : rptr_q;
    cnt_d   = cnt_q;
    if (wr_acc && !rd_acc) cnt_d = cnt_q + CW'(1);
    if (rd_acc && !wr_acc) cnt_d = cnt_q - CW'(1);
    // status the observed FIFO must present after this edge
    wack_d  = wr_acc;
    ovf_d   = wr_en && !wr_acc;
    udf_d   = rd_en && (cnt_q == '0);
    armed_d = rd_acc;
    edata_d = rd_acc ? mem_q[rptr_q] : edata_q;
  end

  always_comb begin
    err_v    = '0;
    err_v[0] = full        != (cnt_q == CNT_FULL);
    err_v[1] = empty       != (cnt_q == '0);
    err_v[2] = almostfull  != (cnt_q == CNT_AF);
    err_v[3] = almostempty != (cnt_q == CNT_ONE);
    err_v[4] = wr_ack      != wack_q;
    err_v[5] = overflow    != ovf_q;
    err_v[6] = underflow   != udf_q;
    err_v[7] = armed_q && (data_out != edata_q);
  end

  always_comb begin
    cc_d = cc_q;
    ec_d = ec_q;
    mm_d = mm_q;
    ef_d = ef_q;
    if (!freeze) begin
      mm_d = |err_v;
      if (|err_v) begin
        if (ec_q != CNT_MAX) ec_d = ec_q + CNT_W'(1);
      end else begin
        if (cc_q != CNT_MAX) cc_d = cc_q + CNT_W'(1);
      end
`ifdef FIFO_CHK_STICKY_EN
      ef_d = ef_q | err_v;
`else
      ef_d = err_v;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wack_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      armed_q <= 1'b0;
      edata_q <= '0;
      cc_q    <= '0;
      ec_q    <= '0;
      mm_q    <= 1'b0;
      ef_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      wack_q  <= wack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      armed_q <= armed_d;
      edata_q <= edata_d;
      cc_q    <= cc_d;
      ec_q    <= ec_d;
      mm_q    <= mm_d;
      ef_q    <= ef_d;
    end
  end

  assign correct_count = cc_q;
  assign error_count   = ec_q;
  assign mismatch      = mm_q;
  assign error_flags   = ef_q;

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// tb_fifo_shadow_checker: drives an ideal FIFO's signals with injected faults
// and scoreboards the checker's tallies against a queue-based model.
module tb_fifo_shadow_checker;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out = '0;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic        almostfull = 1'b0;
  logic        almostempty = 1'b0;
  logic        wr_ack = 1'b0;
  logic        overflow = 1'b0;
  logic        underflow = 1'b0;
  logic        freeze = 1'b0;

  logic [15:0] cc, ec;
  logic        mm;
  logic [7:0]  ef;
  logic [3:0]  cc4, ec4;
  logic        mm4;
  logic [7:0]  ef4;

  always #5 clk = ~clk;

  fifo_shadow_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .freeze(freeze),
    .correct_count(cc), .error_count(ec),
    .mismatch(mm), .error_flags(ef)
  );

  fifo_shadow_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .freeze(freeze),
    .correct_count(cc4), .error_count(ec4),
    .mismatch(mm4), .error_flags(ef4)
  );

  typedef struct {
    int       nc;
    int       ne;
    bit       mm;
    bit [7:0] ef;
  } exp_t;

  exp_t sb[$];

  // ideal FIFO + checker model
  logic [15:0] q[$];
  bit          m_wack, m_ovf, m_udf, m_armed;
  logic [15:0] m_dout;
  int          n_c, n_e;
  bit          e_mm;
  bit [7:0]    e_ef;

  int  errors = 0;
  int  checks = 0;
  bit  done = 1'b0;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit f,
                      input bit rs, input logic [15:0] d,
                      input bit [7:0] mask);
    int   cnt;
    bit   wa, ra;
    bit [7:0] ev;
    exp_t e;
    @(negedge clk);
    cnt = q.size();
    full        = (cnt == DEPTH) ^ mask[0];
    empty       = (cnt == 0) ^ mask[1];
    almostfull  = (cnt == DEPTH - 1) ^ mask[2];
    almostempty = (cnt == 1) ^ mask[3];
    wr_ack      = m_wack ^ mask[4];
    overflow    = m_ovf ^ mask[5];
    underflow   = m_udf ^ mask[6];
    if (m_armed)
      data_out = m_dout ^ (mask[7] ? 16'h0001 : 16'h0000);
    else
      data_out = 16'($urandom);
    wr_en   = w;
    rd_en   = r;
    freeze  = f;
    rst     = rs;
    data_in = d;
    if (rs) begin
      q.delete();
      m_wack = 0; m_ovf = 0; m_udf = 0; m_armed = 0;
      n_c = 0; n_e = 0; e_mm = 0; e_ef = '0;
    end else begin
      if (!f) begin
        ev = mask;
        if (!m_armed) ev[7] = 1'b0;
        if (ev == 0) n_c++;
        else n_e++;
        e_mm = (ev != 0);
`ifdef FIFO_CHK_STICKY_EN
        e_ef = e_ef | ev;
`else
        e_ef = ev;
`endif
      end
      wa = w && (cnt < DEPTH);
      ra = r && (cnt > 0);
      m_wack  = wa;
      m_ovf   = w && !wa;
      m_udf   = r && (cnt == 0);
      m_armed = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    e.nc = n_c; e.ne = n_e; e.mm = e_mm; e.ef = e_ef;
    sb.push_back(e);
  endtask

  // monitor: each edge's expectation is pushed at the preceding negedge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("correct_count", int'(cc), sat(e.nc, 65535));
        chk("error_count", int'(ec), sat(e.ne, 65535));
        chk("mismatch", int'(mm), int'(e.mm));
        chk("error_flags", int'(ef), int'(e.ef));
        chk("correct_count4", int'(cc4), sat(e.nc, 15));
        chk("error_count4", int'(ec4), sat(e.ne, 15));
        chk("error_flags4", int'(ef4), int'(e.ef));
      end
    end
  end

  initial begin : stim
    bit w, r, f, rs;
    bit [7:0] mk;
    m_wack = 0; m_ovf = 0; m_udf = 0; m_armed = 0; m_dout = '0;
    n_c = 0; n_e = 0; e_mm = 0; e_ef = '0;
    repeat (3) step(0, 0, 0, 1, '0, '0);
    // fill with 1..8 then drain
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 16'(i), '0);
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, '0, '0);
    repeat (2) step(0, 0, 0, 0, '0, '0);
    // read at empty, FIFO fails to raise underflow
    step(0, 1, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, 8'h40);
    repeat (2) step(0, 0, 0, 0, '0, '0);
    // full then simultaneous write and read
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16'(100 + i), '0);
    step(1, 1, 0, 0, 16'h7777, '0);
    step(0, 0, 0, 0, '0, '0);
    step(1, 1, 0, 0, 16'h7778, '0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, '0, '0);
    // corrupted read data then matching cycles
    step(0, 0, 0, 1, '0, '0);
    step(1, 0, 0, 0, 16'hA5A5, '0);
    step(0, 1, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, 8'h80);
    repeat (3) step(0, 0, 0, 0, '0, '0);
    // freeze with mismatching stimulus and 5 writes
    step(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 10; i++)
      step(i < 5, 0, 1, 0, 16'(i + 50), 8'h3F);
    repeat (3) step(0, 0, 0, 0, '0, '0);
    // saturation of the narrow error counter, then reset
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0, 8'h01);
    step(0, 0, 0, 1, '0, '0);
    step(0, 0, 0, 0, '0, '0);
    // random traffic
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 120; i++) begin
        w  = ($urandom_range(99) < (s[0] ? 70 : 35));
        r  = ($urandom_range(99) < (s[0] ? 35 : 70));
        f  = ($urandom_range(99) < 5);
        rs = ($urandom_range(199) == 0);
        mk = ($urandom_range(99) < 12) ? 8'($urandom) : 8'h00;
        step(w, r, f, rs, 16'($urandom), mk);
      end
    end
    step(0, 0, 0, 0, '0, '0);
    @(posedge clk);
    #2;
    done = 1'b1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

endmodule
